// File: rtl/dmem_copy_engine_if.sv
// Memory-port bundle between dmem_copy_engine (master) and Data_Memory (slave).
// Shared address, registered write, combinational gated read.
interface dmem_copy_engine_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();

  logic [ADDR_W-1:0] mem_access_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_en;
  logic              mem_read;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output mem_access_addr,
    output mem_write_data,
    output mem_write_en,
    output mem_read,
    input  mem_read_data
  );

  modport slave (
    input  mem_access_addr,
    input  mem_write_data,
    input  mem_write_en,
    input  mem_read,
    output mem_read_data
  );

endinterface

// File: rtl/dmem_copy_engine.sv
// Block copy / constant fill engine driving the single-port Data_Memory.
// Define DMEM_VERIFY_EN to add a readback VF cycle after every write with a sticky err flag.
module dmem_copy_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] fill_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  words_done_o,
  output logic              err_o,
  dmem_copy_engine_if.master mem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
`ifdef DMEM_VERIFY_EN
    S_VF,
`endif
    S_DONE
  } state_t;

  state_t            state_q;
  logic              mode_q;
  logic [ADDR_W-1:0] srcPtr_q;
  logic [ADDR_W-1:0] dstPtr_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] fill_q;
  logic [LEN_W-1:0]  wordsDone_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dataBuf_q;
  logic              we_q;
  logic              rd_q;

  logic [ADDR_W-1:0] srcInc_d;
  logic [ADDR_W-1:0] dstInc_d;
  logic [LEN_W-1:0]  wordsInc_d;

  assign srcInc_d   = srcPtr_q + 1'b1;
  assign dstInc_d   = dstPtr_q + 1'b1;
  assign wordsInc_d = wordsDone_q + 1'b1;

`ifdef DMEM_VERIFY_EN
  logic err_q;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Strobes default low every cycle; each state re-asserts only what the next state needs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      srcPtr_q    <= '0;
      dstPtr_q    <= '0;
      len_q       <= '0;
      fill_q      <= '0;
      wordsDone_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      dataBuf_q   <= '0;
      we_q        <= 1'b0;
      rd_q        <= 1'b0;
`ifdef DMEM_VERIFY_EN
      err_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      rd_q   <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            mode_q      <= mode_i;
            srcPtr_q    <= src_addr_i;
            dstPtr_q    <= dst_addr_i;
            len_q       <= len_i;
            fill_q      <= fill_data_i;
            wordsDone_q <= '0;
`ifdef DMEM_VERIFY_EN
            err_q       <= 1'b0;
`endif
            if (len_i == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (!mode_i) begin
              state_q <= S_RD;
              busy_q  <= 1'b1;
              rd_q    <= 1'b1;
              addr_q  <= src_addr_i;
            end else begin
              state_q   <= S_WR;
              busy_q    <= 1'b1;
              we_q      <= 1'b1;
              addr_q    <= dst_addr_i;
              dataBuf_q <= fill_data_i;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_RD: begin
          state_q   <= S_WR;
          we_q      <= 1'b1;
          addr_q    <= dstPtr_q;
          dataBuf_q <= mem.mem_read_data;
        end

`ifdef DMEM_VERIFY_EN
        // Address and data registers still hold the word just written for the readback.
        S_WR: begin
          wordsDone_q <= wordsInc_d;
          srcPtr_q    <= srcInc_d;
          dstPtr_q    <= dstInc_d;
          state_q     <= S_VF;
          rd_q        <= 1'b1;
        end

        S_VF: begin
          if (mem.mem_read_data != dataBuf_q) begin
            err_q <= 1'b1;
          end
          if (wordsDone_q == len_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (!mode_q) begin
            state_q <= S_RD;
            rd_q    <= 1'b1;
            addr_q  <= srcPtr_q;
          end else begin
            state_q   <= S_WR;
            we_q      <= 1'b1;
            addr_q    <= dstPtr_q;
            dataBuf_q <= fill_q;
          end
        end
`else
        S_WR: begin
          wordsDone_q <= wordsInc_d;
          srcPtr_q    <= srcInc_d;
          dstPtr_q    <= dstInc_d;
          if (wordsInc_d == len_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (!mode_q) begin
            state_q <= S_RD;
            rd_q    <= 1'b1;
            addr_q  <= srcInc_d;
          end else begin
            state_q   <= S_WR;
            we_q      <= 1'b1;
            addr_q    <= dstInc_d;
            dataBuf_q <= fill_q;
          end
        end
`endif

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign words_done_o        = wordsDone_q;
  assign mem.mem_access_addr = addr_q;
  assign mem.mem_write_data  = dataBuf_q;
  assign mem.mem_write_en    = we_q;
  assign mem.mem_read        = rd_q;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Directed self-checking bench for dmem_copy_engine with a behavioural Data_Memory model.
// Verify-mode expectations switch on when DMEM_VERIFY_EN is defined.
module tb_dmem_copy_engine;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 4;
`ifdef DMEM_VERIFY_EN
  localparam int VFY = 1;
`else
  localparam int VFY = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic              mode_i;
  logic [ADDR_W-1:0] src_addr_i;
  logic [ADDR_W-1:0] dst_addr_i;
  logic [LEN_W-1:0]  len_i;
  logic [DATA_W-1:0] fill_data_i;
  logic              busy_o;
  logic              done_o;
  logic [LEN_W-1:0]  words_done_o;
  logic              err_o;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  dmem_copy_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_copy_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .src_addr_i  (src_addr_i),
    .dst_addr_i  (dst_addr_i),
    .len_i       (len_i),
    .fill_data_i (fill_data_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .words_done_o(words_done_o),
    .err_o       (err_o),
    .mem         (bus)
  );

  // Data_Memory model: registered write, gated combinational read, backdoor preload port.
  logic [DATA_W-1:0] memArray [0:65535];
  logic              bdWe = 1'b0;
  logic [ADDR_W-1:0] bdAddr = '0;
  logic [DATA_W-1:0] bdData = '0;
  logic              forceMismatch = 1'b0;

  always @(posedge clk) begin
    if (bus.mem_write_en) memArray[bus.mem_access_addr] <= bus.mem_write_data;
    else if (bdWe)        memArray[bdAddr] <= bdData;
  end

  assign bus.mem_read_data = bus.mem_read ?
         (memArray[bus.mem_access_addr] ^ {{(DATA_W-1){1'b0}}, forceMismatch}) : '0;

  // Bus activity monitor sampled on the inactive edge.
  int                readCycles = 0;
  int                writeCycles = 0;
  int                bothCycles = 0;
  logic [ADDR_W-1:0] lastWrAddr = '0;
  logic [ADDR_W-1:0] prevWrAddr = '0;

  always @(negedge clk) begin
    if (bus.mem_read)     readCycles++;
    if (bus.mem_write_en) begin
      writeCycles++;
      prevWrAddr = lastWrAddr;
      lastWrAddr = bus.mem_access_addr;
    end
    if (bus.mem_read && bus.mem_write_en) bothCycles++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else passes++;
  endtask

  task automatic bdWrite(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    bdWe   = 1'b1;
    bdAddr = a;
    bdData = d;
    @(negedge clk);
    bdWe   = 1'b0;
  endtask

  // One-edge start pulse; returns on the negedge right after the accepting edge.
  task automatic applyStimulus(input logic m, input logic [ADDR_W-1:0] s,
                               input logic [ADDR_W-1:0] d, input logic [LEN_W-1:0] l,
                               input logic [DATA_W-1:0] f);
    @(negedge clk);
    mode_i      = m;
    src_addr_i  = s;
    dst_addr_i  = d;
    len_i       = l;
    fill_data_i = f;
    start_i     = 1'b1;
    @(negedge clk);
    start_i     = 1'b0;
  endtask

  task automatic waitDone(input int maxCycles, output int cycles);
    cycles = 1;
    while (!done_o && cycles < maxCycles) begin
      @(negedge clk);
      cycles++;
    end
    if (!done_o) checkOutput("doneTimeout", 32'(0), 32'(1));
  endtask

  function automatic int expCycles(input logic m, input int l);
    if (l == 0) return 1;
    return l * ((m ? 1 : 2) + VFY) + 1;
  endfunction

  int cyc;
  int r0;
  int w0;

  initial begin
    rst = 1'b1; start_i = 1'b0; mode_i = 1'b0;
    src_addr_i = '0; dst_addr_i = '0; len_i = '0; fill_data_i = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy",  32'(busy_o), 32'(0));
    checkOutput("rstDone",  32'(done_o), 32'(0));
    checkOutput("rstErr",   32'(err_o), 32'(0));
    checkOutput("rstWords", 32'(words_done_o), 32'(0));
    checkOutput("rstWe",    32'(bus.mem_write_en), 32'(0));
    checkOutput("rstRd",    32'(bus.mem_read), 32'(0));
    checkOutput("rstAddr",  32'(bus.mem_access_addr), 32'(0));
    checkOutput("rstWdata", 32'(bus.mem_write_data), 32'(0));
    rst = 1'b0;

    for (int i = 0; i < 8; i++) bdWrite(16'(i), 16'(10 + i));
    bdWrite(16'd30, 16'hBEEF);

    $display("[TB] reset during write");
    applyStimulus(1'b0, 16'd0, 16'd30, 4'd3, 16'h0);
    checkOutput("t1RdStrobe", 32'(bus.mem_read), 32'(1));
    checkOutput("t1RdAddr",   32'(bus.mem_access_addr), 32'(0));
    @(negedge clk);
    checkOutput("t1WrStrobe", 32'(bus.mem_write_en), 32'(1));
    checkOutput("t1WrAddr",   32'(bus.mem_access_addr), 32'(30));
    rst = 1'b1;
    #1;
    checkOutput("t1WeDrop",   32'(bus.mem_write_en), 32'(0));
    checkOutput("t1RdDrop",   32'(bus.mem_read), 32'(0));
    checkOutput("t1BusyDrop", 32'(busy_o), 32'(0));
    @(negedge clk);
    checkOutput("t1Target",   32'(memArray[30]), 32'(16'hBEEF));
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t1IdleBusy", 32'(busy_o), 32'(0));
    checkOutput("t1IdleDone", 32'(done_o), 32'(0));

    $display("[TB] copy src=0 dst=4 len=3");
    r0 = readCycles; w0 = writeCycles;
    applyStimulus(1'b0, 16'd0, 16'd4, 4'd3, 16'h0);
    checkOutput("t2BusyStart", 32'(busy_o), 32'(1));
    waitDone(40, cyc);
    checkOutput("t2Cycles", 32'(cyc), 32'(expCycles(1'b0, 3)));
    checkOutput("t2DoneNotBusy", 32'(busy_o), 32'(0));
    checkOutput("t2Words",  32'(words_done_o), 32'(3));
    @(negedge clk);
    checkOutput("t2DonePulse", 32'(done_o), 32'(0));
    checkOutput("t2Reads",  32'(readCycles - r0), 32'(3 * (1 + VFY)));
    checkOutput("t2Writes", 32'(writeCycles - w0), 32'(3));
    checkOutput("t2Mem4",   32'(memArray[4]), 32'(10));
    checkOutput("t2Mem5",   32'(memArray[5]), 32'(11));
    checkOutput("t2Mem6",   32'(memArray[6]), 32'(12));
    checkOutput("t2AddrHold", 32'(bus.mem_access_addr), 32'(6));
    checkOutput("t2Err",    32'(err_o), 32'(0));

    $display("[TB] fill dst=2 len=4");
    r0 = readCycles; w0 = writeCycles;
    applyStimulus(1'b1, 16'd0, 16'd2, 4'd4, 16'hA5A5);
    waitDone(40, cyc);
    checkOutput("t3Cycles", 32'(cyc), 32'(expCycles(1'b1, 4)));
    checkOutput("t3Words",  32'(words_done_o), 32'(4));
    @(negedge clk);
    checkOutput("t3Writes", 32'(writeCycles - w0), 32'(4));
    checkOutput("t3Reads",  32'(readCycles - r0), 32'(4 * VFY));
    for (int i = 2; i < 6; i++) checkOutput("t3MemFill", 32'(memArray[i]), 32'(16'hA5A5));
    checkOutput("t3Mem1",   32'(memArray[1]), 32'(11));
    checkOutput("t3Mem6",   32'(memArray[6]), 32'(12));

    $display("[TB] zero-length command");
    r0 = readCycles; w0 = writeCycles;
    applyStimulus(1'b0, 16'd0, 16'd40, 4'd0, 16'h0);
    waitDone(10, cyc);
    checkOutput("t4Cycles", 32'(cyc), 32'(1));
    checkOutput("t4Busy",   32'(busy_o), 32'(0));
    @(negedge clk);
    checkOutput("t4Reads",  32'(readCycles - r0), 32'(0));
    checkOutput("t4Writes", 32'(writeCycles - w0), 32'(0));

    $display("[TB] start held while busy, back-to-back in DONE");
    @(negedge clk);
    mode_i = 1'b0; src_addr_i = 16'd0; dst_addr_i = 16'd8; len_i = 4'd2; fill_data_i = 16'h0;
    start_i = 1'b1;
    @(negedge clk);
    mode_i = 1'b1; dst_addr_i = 16'd12; len_i = 4'd1; fill_data_i = 16'h5555;
    waitDone(40, cyc);
    checkOutput("t5CyclesA", 32'(cyc), 32'(expCycles(1'b0, 2)));
    @(negedge clk);
    start_i = 1'b0;
    checkOutput("t5Accepted", 32'(busy_o), 32'(1));
    waitDone(20, cyc);
    checkOutput("t5CyclesB", 32'(cyc), 32'(expCycles(1'b1, 1)));
    @(negedge clk);
    checkOutput("t5Mem8",  32'(memArray[8]), 32'(10));
    checkOutput("t5Mem9",  32'(memArray[9]), 32'(11));
    checkOutput("t5Mem12", 32'(memArray[12]), 32'(16'h5555));

    $display("[TB] fill across address wrap");
    applyStimulus(1'b1, 16'd0, 16'hFFFF, 4'd2, 16'h1234);
    waitDone(20, cyc);
    checkOutput("t6Cycles",  32'(cyc), 32'(expCycles(1'b1, 2)));
    checkOutput("t6FirstWr", 32'(prevWrAddr), 32'(16'hFFFF));
    checkOutput("t6WrapWr",  32'(lastWrAddr), 32'(16'h0000));
    @(negedge clk);
    checkOutput("t6MemTop",  32'(memArray[16'hFFFF]), 32'(16'h1234));
    checkOutput("t6Mem0",    32'(memArray[0]), 32'(16'h1234));
    checkOutput("t6Mem1",    32'(memArray[1]), 32'(11));

`ifdef DMEM_VERIFY_EN
    $display("[TB] readback mismatch");
    forceMismatch = 1'b1;
    applyStimulus(1'b1, 16'd0, 16'd50, 4'd2, 16'h7777);
    waitDone(20, cyc);
    checkOutput("t6vCycles",  32'(cyc), 32'(expCycles(1'b1, 2)));
    checkOutput("t6vErrDone", 32'(err_o), 32'(1));
    forceMismatch = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t6vErrHeld", 32'(err_o), 32'(1));
    checkOutput("t6vMem50",   32'(memArray[50]), 32'(16'h7777));
    applyStimulus(1'b1, 16'd0, 16'd60, 4'd0, 16'h0);
    checkOutput("t6vErrClr",  32'(err_o), 32'(0));
`endif

    checkOutput("noDualStrobe", 32'(bothCycles), 32'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
